chip8_sprite_engine: RTL and testbench
======================================

Name: chip8_sprite_engine

Overview:
- Parametrised successor to the single-row XOR display stage. Holds the framebuffer internally as DISP_H rows of DISP_W bits.
- Executes a complete DRW command autonomously: fetches sprite bytes from memory over a req/valid handshake, XORs them row by row, and accumulates collision.
- Supports CHIP-8 (64x32, 8-wide) and SCHIP (128x64, 16x16) geometry, a wrap or clip edge mode, a full-screen clear, and a registered scanout read port for the video block.

Parameters:
- DISP_W, 64, display width in pixels (power of 2, 64 or 128)
- DISP_H, 32, display height in rows (power of 2, 32 or 64)
- SPRITE_W, 8, sprite row width in bits (8 or 16); BPR = SPRITE_W/8 bytes per row
- ADDR_W, 12, sprite memory address width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  draw command strobe
- clear  in  1  clear-screen command strobe
- clip_en  in  1  1 = clip at edges, 0 = wrap; sampled when start is accepted
- x  in  8  sprite X origin
- y  in  7  sprite Y origin
- n  in  4  row count; 0 = 16 rows
- base_addr  in  ADDR_W  sprite address (I register)
- busy  out  1  engine not idle
- done  out  1  one-cycle pulse at command completion
- collision  out  1  VF result of the last draw
- collision_rows  out  5  number of rows with at least one pixel erased
- mem_req  out  1  sprite byte read request
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  8  read data
- mem_valid  in  1  read data valid (arbitrary latency ≥1 cycle)
- rd_row  in  log2(DISP_H)  scanout row select
- rd_data  out  DISP_W  scanout row data, registered

Behaviour:
- Reset (async assert, sync deassert): framebuffer all 0; busy=0, done=0, collision=0, collision_rows=0, mem_req=0, mem_addr=0, rd_data=0; FSM=IDLE.
- Reset mid-command aborts the command immediately. No done pulse is produced.
- FSM states: IDLE, CLEAR, FETCH, APPLY, DONE.
- IDLE:
  - clear → CLEAR.
  - Else start → latch the command, then FETCH. On latch: x0=x mod DISP_W, y0=y mod DISP_H, rows=(n==0)?16:n; clear collision and collision_rows.
  - clear and start in the same cycle: clear wins; start is dropped.
  - start and clear are ignored while busy.
- CLEAR: zeroes one row per cycle, rows 0..DISP_H-1, then DONE. Duration is DISP_H cycles. collision is unchanged.
- FETCH, for row r (0..rows-1) and byte b (0..BPR-1):
  - mem_addr = base_addr + r*BPR + b, mod 2^ADDR_W.
  - mem_req stays high with mem_addr stable until the cycle mem_valid=1; mem_rdata is captured that cycle.
  - mem_req drops for at least one cycle between bytes. Only one request is outstanding at a time.
  - After the last byte of the row → APPLY.
- Clip mode: a row with y0+r ≥ DISP_H is skipped with no fetch. All remaining rows are also skipped, and the FSM goes to DONE.
- APPLY (1 cycle):
  - Target row ty = (y0+r) mod DISP_H.
  - Sprite bit k (MSB first) maps to column cx = x0+k. Wrap mode: cx mod DISP_W. Clip mode: bits with cx ≥ DISP_W are dropped.
  - new_row = old_row XOR mask.
  - If (old_row AND mask) ≠ 0: collision←1 and collision_rows←collision_rows+1.
  - Then the next row → FETCH, or after the last row → DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in every state except IDLE.
- Command latency: draw = Σ(memory latencies) + per-row overhead + 2 cycles. clear = DISP_H+1 cycles from start to done.
- Scanout: rd_data <= fb[rd_row] every cycle, regardless of FSM state.
  - On a same-cycle APPLY/CLEAR write to rd_row, rd_data returns the pre-write contents (read-before-write).
- Pixel bit order: column 0 = MSB of the row word (bit DISP_W-1).

Test Plan:
- Draw x=0, y=0, n=5, sprite bytes F0,90,90,90,F0, one-cycle memory latency → rows 0..4 MSBs are F0,90,90,90,F0; collision=0; collision_rows=0; exactly 5 mem_req handshakes at addresses base..base+4.
- Repeat the identical draw → rows 0..4 are all 0; collision=1; collision_rows=5.
- Wrap mode, x=60, y=30, n=3, bytes FF → rows 30, 31, 0 each have columns 60–63 and 0–3 set; collision=0.
- Clip mode, same command → rows 30 and 31 have only columns 60–63 set; row 0 is untouched; only 2 fetches are issued.
- SPRITE_W=16, DISP_W=128, DISP_H=64, n=0, base_addr=FFE (wrap to 000) → 32 fetches at FFE, FFF, 000, …; 16 rows of 16 bits drawn.
- Assert clear and start in the same cycle, then pulse start while busy, then assert reset_n low mid-fetch → clear executes in 64 cycles with done=1 once; start is ignored; on reset, all outputs are 0 immediately and no done pulse occurs.

Source files
------------

// File: rtl/chip8_sprite_engine.sv
// chip8_sprite_engine
// Autonomous CHIP-8 / SCHIP sprite draw engine with an internal framebuffer.
// A DRW command fetches sprite bytes one at a time over a req/valid handshake,
// XORs each sprite row into the framebuffer and accumulates collision.
// A clear command zeroes the framebuffer one row per cycle.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, clear            command strobes (ignored while busy, clear wins)
//   clip_en                 1 = clip at screen edges, 0 = wrap
//   x, y, n, base_addr      sprite origin, row count (0 = 16), sprite address
//   busy, done              engine active, one-cycle completion pulse
//   collision               VF result of the last draw
//   collision_rows          rows of the last draw with at least one pixel erased
//   mem_req, mem_addr       sprite byte read request / address
//   mem_rdata, mem_valid    sprite byte read data / valid
//   rd_row, rd_data         registered scanout read port
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start or clear
// CLEAR  | zeroing framebuffer rows 0..DISP_H-1, one per cycle
// FETCH  | requesting the bytes of the current sprite row
// APPLY  | XOR the assembled sprite row into the target framebuffer row
// DONE   | done pulse, back to IDLE next cycle
module chip8_sprite_engine #(
   parameter int DISP_W   = 64,
   parameter int DISP_H   = 32,
   parameter int SPRITE_W = 8,
   parameter int ADDR_W   = 12
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic                        clear,
   input  logic                        clip_en,
   input  logic [7:0]                  x,
   input  logic [6:0]                  y,
   input  logic [3:0]                  n,
   input  logic [ADDR_W-1:0]           base_addr,
   output logic                        busy,
   output logic                        done,
   output logic                        collision,
   output logic [4:0]                  collision_rows,
   output logic                        mem_req,
   output logic [ADDR_W-1:0]           mem_addr,
   input  logic [7:0]                  mem_rdata,
   input  logic                        mem_valid,
   input  logic [$clog2(DISP_H)-1:0]   rd_row,
   output logic [DISP_W-1:0]           rd_data
);

   localparam int BPR = SPRITE_W / 8;
   localparam int CW  = $clog2(DISP_W);
   localparam int RW  = $clog2(DISP_H);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FETCH,
      S_APPLY,
      S_DONE
   } state_t;

   state_t               state;
   logic [DISP_W-1:0]    fb [DISP_H];
   logic [CW-1:0]        x0;
   logic [RW-1:0]        y0;
   logic [4:0]           rows;
   logic [4:0]           r;
   logic                 clip_q;
   logic [ADDR_W-1:0]    ptr;
   logic [0:0]           byte_idx;
   logic [SPRITE_W-1:0]  sprite_q;
   logic [RW-1:0]        clr_row;

   logic [RW:0]          row_sum;
   logic [RW-1:0]        ty;
   logic                 row_off;
   logic [2*DISP_W-1:0]  placed;
   logic [DISP_W-1:0]    mask;
   logic [DISP_W-1:0]    old_row;
   logic                 last_byte;

   // y0 < DISP_H and r <= 16 <= DISP_H, so the sum never reaches 2*DISP_H:
   // the top bit alone says the row falls off the bottom edge.
   assign row_sum = {1'b0, y0} + (RW+1)'(r);
   assign ty      = row_sum[RW-1:0];
   assign row_off = row_sum[RW];

   // Sprite shifted right by x0 inside a double-width window: the upper half
   // holds the on-screen columns, the lower half the columns past the right
   // edge, which fold back to column 0 when wrapping.
   assign placed  = {sprite_q, {(2*DISP_W-SPRITE_W){1'b0}}} >> x0;
   assign mask    = clip_q ? placed[2*DISP_W-1:DISP_W]
                           : (placed[2*DISP_W-1:DISP_W] | placed[DISP_W-1:0]);
   assign old_row = fb[ty];
   assign last_byte = (byte_idx == 1'(BPR-1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         collision      <= 1'b0;
         collision_rows <= '0;
         mem_req        <= 1'b0;
         mem_addr       <= '0;
         rd_data        <= '0;
         x0             <= '0;
         y0             <= '0;
         rows           <= '0;
         r              <= '0;
         clip_q         <= 1'b0;
         ptr            <= '0;
         byte_idx       <= '0;
         sprite_q       <= '0;
         clr_row        <= '0;
         for (int i = 0; i < DISP_H; i++) fb[i] <= '0;
      end else begin
         // Non-blocking read of fb gives read-before-write against APPLY/CLEAR.
         rd_data <= fb[rd_row];
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (clear) begin
                  clr_row <= '0;
                  busy    <= 1'b1;
                  state   <= S_CLEAR;
               end else if (start) begin
                  x0             <= CW'(x % 8'(DISP_W));
                  y0             <= RW'(y % 7'(DISP_H));
                  rows           <= (n == 4'd0) ? 5'd16 : {1'b0, n};
                  r              <= '0;
                  clip_q         <= clip_en;
                  ptr            <= base_addr;
                  byte_idx       <= '0;
                  collision      <= 1'b0;
                  collision_rows <= '0;
                  busy           <= 1'b1;
                  state          <= S_FETCH;
               end
            end
            S_CLEAR: begin
               fb[clr_row] <= '0;
               clr_row     <= clr_row + 1'b1;
               if (clr_row == RW'(DISP_H-1)) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_FETCH: begin
               if (!mem_req) begin
                  // Once one row falls off the bottom, every later row does too.
                  if (clip_q && row_off) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     mem_req  <= 1'b1;
                     mem_addr <= ptr;
                  end
               end else if (mem_valid) begin
                  mem_req <= 1'b0;
                  ptr     <= ptr + 1'b1;
                  for (int i = 0; i < BPR; i++) begin
                     if (byte_idx == 1'(i)) sprite_q[SPRITE_W-1-8*i -: 8] <= mem_rdata;
                  end
                  if (last_byte) begin
                     byte_idx <= '0;
                     state    <= S_APPLY;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
            end
            S_APPLY: begin
               fb[ty] <= old_row ^ mask;
               if (|(old_row & mask)) begin
                  collision      <= 1'b1;
                  collision_rows <= collision_rows + 5'd1;
               end
               if (r == rows - 5'd1) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  r     <= r + 5'd1;
                  state <= S_FETCH;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chip8_sprite_engine.sv
// Testbench for chip8_sprite_engine: one CHIP-8 geometry instance (64x32, 8-wide)
// driven from a command table, and one SCHIP instance (128x64, 16-wide) driven by
// hand-written sequences for address wrap, clear/start collision and reset abort.
module tb_chip8_sprite_engine;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- instance A: 64x32, 8-wide ----------------
   logic        a_start = 0, a_clear = 0, a_clip = 0;
   logic [7:0]  a_x = 0;
   logic [6:0]  a_y = 0;
   logic [3:0]  a_n = 0;
   logic [11:0] a_base = 0;
   logic        a_busy, a_done, a_coll, a_req;
   logic [4:0]  a_crows;
   logic [11:0] a_addr;
   logic [7:0]  a_rdata = 0;
   logic        a_valid = 0;
   logic [4:0]  a_rd_row = 0;
   logic [63:0] a_rd_data;

   chip8_sprite_engine #(.DISP_W(64), .DISP_H(32), .SPRITE_W(8), .ADDR_W(12)) dut_a (
      .clk(clk), .reset_n(rst_n), .start(a_start), .clear(a_clear), .clip_en(a_clip),
      .x(a_x), .y(a_y), .n(a_n), .base_addr(a_base), .busy(a_busy), .done(a_done),
      .collision(a_coll), .collision_rows(a_crows), .mem_req(a_req), .mem_addr(a_addr),
      .mem_rdata(a_rdata), .mem_valid(a_valid), .rd_row(a_rd_row), .rd_data(a_rd_data));

   // ---------------- instance B: 128x64, 16-wide ----------------
   logic         b_start = 0, b_clear = 0, b_clip = 0;
   logic [7:0]   b_x = 0;
   logic [6:0]   b_y = 0;
   logic [3:0]   b_n = 0;
   logic [11:0]  b_base = 0;
   logic         b_busy, b_done, b_coll, b_req;
   logic [4:0]   b_crows;
   logic [11:0]  b_addr;
   logic [7:0]   b_rdata = 0;
   logic         b_valid = 0;
   logic [5:0]   b_rd_row = 0;
   logic [127:0] b_rd_data;

   chip8_sprite_engine #(.DISP_W(128), .DISP_H(64), .SPRITE_W(16), .ADDR_W(12)) dut_b (
      .clk(clk), .reset_n(rst_n), .start(b_start), .clear(b_clear), .clip_en(b_clip),
      .x(b_x), .y(b_y), .n(b_n), .base_addr(b_base), .busy(b_busy), .done(b_done),
      .collision(b_coll), .collision_rows(b_crows), .mem_req(b_req), .mem_addr(b_addr),
      .mem_rdata(b_rdata), .mem_valid(b_valid), .rd_row(b_rd_row), .rd_data(b_rd_data));

   // ---------------- memory models + protocol monitors ----------------
   logic [7:0]  a_mem [4096];
   logic [7:0]  b_mem [4096];
   logic [11:0] a_log [$];
   logic [11:0] b_log [$];
   int a_lat = 1, b_lat = 1, a_wait = 0, b_wait = 0;
   int a_perr = 0, b_perr = 0, a_dones = 0, b_dones = 0;
   logic a_preq = 0, a_pval = 0, b_preq = 0, b_pval = 0;
   logic [11:0] a_paddr = 0, b_paddr = 0;

   always @(negedge clk) begin
      if (a_preq && !a_pval && a_req && a_addr !== a_paddr) a_perr++;
      if (a_preq && a_pval && a_req) a_perr++;
      if (a_done) a_dones++;
      if (a_req && !a_valid) begin
         if (a_wait >= a_lat) begin
            a_valid = 1'b1;
            a_rdata = a_mem[a_addr];
            a_log.push_back(a_addr);
            a_wait  = 0;
         end else a_wait++;
      end else begin
         a_valid = 1'b0;
         if (!a_req) a_wait = 0;
      end
      a_preq = a_req; a_pval = a_valid; a_paddr = a_addr;
   end

   always @(negedge clk) begin
      if (b_preq && !b_pval && b_req && b_addr !== b_paddr) b_perr++;
      if (b_preq && b_pval && b_req) b_perr++;
      if (b_done) b_dones++;
      if (b_req && !b_valid) begin
         if (b_wait >= b_lat) begin
            b_valid = 1'b1;
            b_rdata = b_mem[b_addr];
            b_log.push_back(b_addr);
            b_wait  = 0;
         end else b_wait++;
      end else begin
         b_valid = 1'b0;
         if (!b_req) b_wait = 0;
      end
      b_preq = b_req; b_pval = b_valid; b_paddr = b_addr;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic read_a(input logic [4:0] row, output logic [63:0] d);
      @(negedge clk); a_rd_row = row;
      @(posedge clk); @(negedge clk); d = a_rd_data;
   endtask

   task automatic read_b(input logic [5:0] row, output logic [127:0] d);
      @(negedge clk); b_rd_row = row;
      @(posedge clk); @(negedge clk); d = b_rd_data;
   endtask

   typedef struct {
      logic        clr;
      logic [7:0]  x;
      logic [6:0]  y;
      logic [3:0]  n;
      logic        clip;
      logic [11:0] base;
      int          lat;
      logic        exp_coll;
      logic [4:0]  exp_crows;
      int          exp_fetch;
   } cmd_t;

   typedef struct {
      int          after;
      logic [4:0]  row;
      logic [63:0] exp;
   } rchk_t;

   task automatic run_a(input cmd_t c, output int cyc, output bit got, output bit bsy);
      @(negedge clk);
      a_x = c.x; a_y = c.y; a_n = c.n; a_clip = c.clip; a_base = c.base; a_lat = c.lat;
      a_log.delete();
      a_clear = c.clr; a_start = !c.clr;
      cyc = 0; got = 0; bsy = 0;
      while (!got && cyc < 3000) begin
         @(posedge clk); cyc++;
         @(negedge clk); a_start = 0; a_clear = 0;
         if (cyc == 1) bsy = a_busy;
         if (a_done) got = 1;
      end
   endtask

   task automatic run_b(input logic clr, input logic st, input logic [7:0] xx,
                        input logic [6:0] yy, input logic [3:0] nn, input logic cl,
                        input logic [11:0] bs, input int lat, input bit poke,
                        output int cyc, output bit got);
      @(negedge clk);
      b_x = xx; b_y = yy; b_n = nn; b_clip = cl; b_base = bs; b_lat = lat;
      b_log.delete();
      b_clear = clr; b_start = st;
      cyc = 0; got = 0;
      while (!got && cyc < 3000) begin
         @(posedge clk); cyc++;
         @(negedge clk); b_start = 0; b_clear = 0;
         if (poke && cyc == 10) begin
            b_base = 12'h555; b_start = 1;
         end
         if (b_done) got = 1;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   cmd_t  cmds [9];
   rchk_t rchks [$];

   initial begin
      int cyc, aerr, d0;
      bit got, bsy;
      logic [63:0]  ra;
      logic [127:0] rb, e;
      logic [7:0]   hi, lo;
      logic [11:0]  ea;

      for (int i = 0; i < 4096; i++) begin
         a_mem[i] = 8'h00;
         b_mem[i] = 8'(i) ^ 8'h5A;
      end
      a_mem[12'h200] = 8'hF0; a_mem[12'h201] = 8'h90; a_mem[12'h202] = 8'h90;
      a_mem[12'h203] = 8'h90; a_mem[12'h204] = 8'hF0;
      a_mem[12'h300] = 8'hFF; a_mem[12'h301] = 8'hFF; a_mem[12'h302] = 8'hFF;
      a_mem[12'h400] = 8'h81;

      //           clr   x       y      n     clip  base     lat coll  crows fetch
      cmds[0] = '{1'b0, 8'd0,   7'd0,  4'd5, 1'b0, 12'h200, 1, 1'b0, 5'd0, 5};
      cmds[1] = '{1'b0, 8'd0,   7'd0,  4'd5, 1'b0, 12'h200, 3, 1'b1, 5'd5, 5};
      cmds[2] = '{1'b0, 8'd60,  7'd30, 4'd3, 1'b0, 12'h300, 2, 1'b0, 5'd0, 3};
      cmds[3] = '{1'b1, 8'd0,   7'd0,  4'd0, 1'b0, 12'h000, 1, 1'b0, 5'd0, 0};
      cmds[4] = '{1'b0, 8'd60,  7'd30, 4'd3, 1'b1, 12'h300, 1, 1'b0, 5'd0, 2};
      cmds[5] = '{1'b0, 8'd60,  7'd30, 4'd3, 1'b1, 12'h300, 4, 1'b1, 5'd2, 2};
      cmds[6] = '{1'b1, 8'd0,   7'd0,  4'd0, 1'b0, 12'h000, 1, 1'b1, 5'd2, 0};
      cmds[7] = '{1'b0, 8'd200, 7'd100,4'd1, 1'b0, 12'h400, 1, 1'b0, 5'd0, 1};
      cmds[8] = '{1'b0, 8'd0,   7'd20, 4'd0, 1'b1, 12'h200, 1, 1'b0, 5'd0, 12};

      rchks.push_back('{0, 5'd0,  64'hF000_0000_0000_0000});
      rchks.push_back('{0, 5'd1,  64'h9000_0000_0000_0000});
      rchks.push_back('{0, 5'd3,  64'h9000_0000_0000_0000});
      rchks.push_back('{0, 5'd4,  64'hF000_0000_0000_0000});
      rchks.push_back('{0, 5'd5,  64'h0});
      rchks.push_back('{1, 5'd0,  64'h0});
      rchks.push_back('{1, 5'd4,  64'h0});
      rchks.push_back('{2, 5'd30, 64'hF000_0000_0000_000F});
      rchks.push_back('{2, 5'd31, 64'hF000_0000_0000_000F});
      rchks.push_back('{2, 5'd0,  64'hF000_0000_0000_000F});
      rchks.push_back('{2, 5'd1,  64'h0});
      rchks.push_back('{2, 5'd29, 64'h0});
      rchks.push_back('{3, 5'd30, 64'h0});
      rchks.push_back('{3, 5'd0,  64'h0});
      rchks.push_back('{4, 5'd30, 64'h0000_0000_0000_000F});
      rchks.push_back('{4, 5'd31, 64'h0000_0000_0000_000F});
      rchks.push_back('{4, 5'd0,  64'h0});
      rchks.push_back('{5, 5'd31, 64'h0});
      rchks.push_back('{7, 5'd4,  64'h0081_0000_0000_0000});
      rchks.push_back('{8, 5'd20, 64'hF000_0000_0000_0000});
      rchks.push_back('{8, 5'd21, 64'h9000_0000_0000_0000});
      rchks.push_back('{8, 5'd24, 64'hF000_0000_0000_0000});
      rchks.push_back('{8, 5'd19, 64'h0});
      rchks.push_back('{8, 5'd31, 64'h0});

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_done", a_done, 0);
      chk("rst_a_coll", a_coll, 0);
      chk("rst_a_crows", a_crows, 0);
      chk("rst_a_req", a_req, 0);
      chk("rst_a_addr", a_addr, 0);
      chk("rst_a_rd", a_rd_data, 0);
      chk("rst_b_busy", b_busy, 0);
      chk("rst_b_req", b_req, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // instance A: command table
      for (int ci = 0; ci < 9; ci++) begin
         run_a(cmds[ci], cyc, got, bsy);
         chk($sformatf("a%0d_done_seen", ci), got, 1);
         chk($sformatf("a%0d_busy", ci), bsy, 1);
         if (cmds[ci].clr) chk($sformatf("a%0d_clear_latency", ci), cyc, 33);
         chk($sformatf("a%0d_collision", ci), a_coll, cmds[ci].exp_coll);
         chk($sformatf("a%0d_collision_rows", ci), a_crows, cmds[ci].exp_crows);
         chk($sformatf("a%0d_fetches", ci), a_log.size(), cmds[ci].exp_fetch);
         aerr = 0;
         for (int i = 0; i < a_log.size(); i++) begin
            ea = cmds[ci].base + 12'(i);
            if (a_log[i] !== ea) aerr++;
         end
         chk($sformatf("a%0d_fetch_addrs", ci), aerr, 0);
         @(negedge clk);
         chk($sformatf("a%0d_done_width", ci), a_done, 0);
         chk($sformatf("a%0d_idle", ci), a_busy, 0);
         foreach (rchks[k]) begin
            if (rchks[k].after == ci) begin
               read_a(rchks[k].row, ra);
               chk($sformatf("a%0d_row%0d", ci, rchks[k].row), ra, rchks[k].exp);
            end
         end
      end
      chk("a_protocol", a_perr, 0);

      // instance B: 16x16 sprite, n=0, address wraps FFE -> 000
      run_b(1'b0, 1'b1, 8'd4, 7'd60, 4'd0, 1'b0, 12'hFFE, 1, 1'b0, cyc, got);
      chk("b_draw_done_seen", got, 1);
      chk("b_draw_collision", b_coll, 0);
      chk("b_draw_fetches", b_log.size(), 32);
      aerr = 0;
      for (int i = 0; i < b_log.size(); i++) begin
         ea = 12'hFFE + 12'(i);
         if (b_log[i] !== ea) aerr++;
      end
      chk("b_draw_fetch_addrs", aerr, 0);
      for (int r = 0; r < 16; r++) begin
         hi = b_mem[12'hFFE + 12'(2*r)];
         lo = b_mem[12'hFFF + 12'(2*r)];
         e  = {hi, lo, 112'b0} >> 4;
         read_b(6'((60 + r) % 64), rb);
         chk($sformatf("b_draw_row%0d", (60 + r) % 64), rb, e);
      end

      // clear and start together, then a start while busy
      d0 = b_dones;
      run_b(1'b1, 1'b1, 8'd0, 7'd0, 4'd1, 1'b0, 12'h100, 1, 1'b1, cyc, got);
      chk("b_clear_done_seen", got, 1);
      chk("b_clear_latency", cyc, 65);
      repeat (5) @(negedge clk);
      chk("b_clear_done_once", b_dones - d0, 1);
      chk("b_clear_no_fetch", b_log.size(), 0);
      chk("b_clear_idle", b_busy, 0);
      read_b(6'd60, rb);
      chk("b_clear_row60", rb, 0);
      read_b(6'd0, rb);
      chk("b_clear_row0", rb, 0);

      // clipped 16-wide sprite at the right edge: only the high byte lands
      run_b(1'b0, 1'b1, 8'd120, 7'd20, 4'd1, 1'b1, 12'h100, 2, 1'b0, cyc, got);
      chk("b_clip_done_seen", got, 1);
      chk("b_clip_fetches", b_log.size(), 2);
      read_b(6'd20, rb);
      chk("b_clip_row20", rb, 128'h5A);
      read_b(6'd21, rb);
      chk("b_clip_row21", rb, 0);

      // reset in the middle of a fetch
      @(negedge clk);
      b_rd_row = 6'd20; b_x = 0; b_y = 0; b_n = 4'd3; b_clip = 0; b_base = 12'h123;
      b_lat = 20; b_start = 1;
      @(negedge clk); b_start = 0;
      cyc = 0;
      while (!b_req && cyc < 50) begin @(negedge clk); cyc++; end
      chk("b_rst_req_seen", b_req, 1);
      repeat (2) @(negedge clk);
      chk("b_rst_pre_busy", b_busy, 1);
      chk("b_rst_pre_addr", b_addr, 12'h123);
      chk("b_rst_pre_rd", b_rd_data, 128'h5A);
      rst_n = 1'b0;
      #1;
      chk("b_rst_busy", b_busy, 0);
      chk("b_rst_done", b_done, 0);
      chk("b_rst_coll", b_coll, 0);
      chk("b_rst_crows", b_crows, 0);
      chk("b_rst_req", b_req, 0);
      chk("b_rst_addr", b_addr, 0);
      chk("b_rst_rd", b_rd_data, 0);
      d0 = b_dones;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("b_rst_no_done", b_dones - d0, 0);
      chk("b_rst_idle", b_busy, 0);
      read_b(6'd20, rb);
      chk("b_rst_fb_cleared", rb, 0);
      chk("b_protocol", b_perr, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
